// File: rtl/circle_seg_pkg.sv
// Segment patterns shared by the circle animation blocks.
package circle_seg_pkg;

    // Active-high segments, bit 7 = dp, bits 6:0 = g..a
    localparam logic [7:0] HIGH_CIRCLE = 8'b0_1100011;
    localparam logic [7:0] LOW_CIRCLE  = 8'b0_1011100;
    localparam logic [7:0] OFF         = 8'b0_0000000;

    // Upper-loop pattern when row is 1, lower-loop pattern otherwise
    function automatic logic [7:0] circle_pattern(input logic row);
        return row ? HIGH_CIRCLE : LOW_CIRCLE;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter with a wrap strobe.
// tick is high during the cycle in which the count goes DIV-1 -> 0, so the
// consumer can act on the very edge where the wrap happens.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // clear suppresses the strobe so a cleared wrap never counts as a step
    assign tick = run && !clear && (cnt_reg == LAST);

    // Counter: clear has priority, otherwise advance while run is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/circle_chaser.sv
// Moves one circle along a closed path over a multiplexed 7-seg bank:
// upper loops left->right, then lower loops right->left, then repeat.
module circle_chaser
    import circle_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STEP_DIV   = 25_000_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pause,
    input  logic                  dir,
    input  logic                  restart,
    output logic [7:0]            seg_display,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] pos_digit,
    output logic                  pos_row,
    output logic                  step_pulse
);

    localparam int            PW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int            IW         = $clog2(2 * NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX   = IW'(2 * NUM_DIGITS - 1);
    localparam logic [IW-1:0] NUM_IDX    = IW'(NUM_DIGITS);
    localparam logic [PW-1:0] LAST_DIGIT = PW'(NUM_DIGITS - 1);

    logic [IW-1:0]         idx_reg;
    logic [PW-1:0]         scan_digit_reg;
    logic [NUM_DIGITS-1:0] digit_onehot;
    logic                  step_tick;
    logic                  scan_tick;

    // Animation timer: runs only while displaying and not frozen;
    // restart or blanking throws away any partial step
    tick_divider #(.DIV(STEP_DIV)) u_step_div (
        .clk   (clk),
        .rst   (rst),
        .run   (enable && !pause),
        .clear (restart || !enable),
        .tick  (step_tick)
    );

    // Scan timer never stops, so the multiplex keeps cycling while paused
    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .rst   (rst),
        .run   (1'b1),
        .clear (1'b0),
        .tick  (scan_tick)
    );

    // Map path index to digit/row; the row is forced low in reset so the
    // whole output bundle reads as zero while rst is asserted
    always_comb begin
        pos_row   = 1'b0;
        pos_digit = '0;
        if (idx_reg < NUM_IDX) begin
            pos_row   = !rst;
            pos_digit = PW'(idx_reg);
        end else begin
            pos_digit = PW'(LAST_IDX - idx_reg);
        end
    end

    // Position update: restart beats a coinciding wrap, wrap moves one slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg    <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= step_tick && !restart;
            if (restart) begin
                idx_reg <= '0;
            end else if (step_tick) begin
                if (dir) begin
                    idx_reg <= (idx_reg == '0) ? LAST_IDX : idx_reg - 1'b1;
                end else begin
                    idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
                end
            end
        end
    end

    // Scan slot advance, wrapping back to digit 0 after the last digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_digit_reg <= '0;
        end else if (scan_tick) begin
            scan_digit_reg <= (scan_digit_reg == LAST_DIGIT) ? '0 : scan_digit_reg + 1'b1;
        end
    end

    // One-hot decode of the active scan slot
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_decode
            assign digit_onehot[gi] = (scan_digit_reg == PW'(gi));
        end
    endgenerate

    // Pin drivers: light the circle only in the slot that owns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_sel   <= '0;
            seg_display <= OFF;
        end else if (!enable) begin
            digit_sel   <= '0;
            seg_display <= OFF;
        end else begin
            digit_sel   <= digit_onehot;
            seg_display <= (scan_digit_reg == pos_digit) ? circle_pattern(pos_row) : OFF;
        end
    end

endmodule

// File: tb/tb_circle_chaser.sv
// Bench for circle_chaser with short dividers (4 digits, step 4, scan 2).
module tb_circle_chaser;

    localparam int N    = 4;
    localparam int STEP = 4;
    localparam int SCAN = 2;

    logic         clk, rst, enable, pause, dir, restart;
    logic [7:0]   seg_display;
    logic [N-1:0] digit_sel;
    logic [1:0]   pos_digit;
    logic         pos_row, step_pulse;

    circle_chaser #(.NUM_DIGITS(N), .STEP_DIV(STEP), .SCAN_DIV(SCAN)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pause       (pause),
        .dir         (dir),
        .restart     (restart),
        .seg_display (seg_display),
        .digit_sel   (digit_sel),
        .pos_digit   (pos_digit),
        .pos_row     (pos_row),
        .step_pulse  (step_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: path position, timer counts and expected pin values
    int           m_idx, m_stepc, m_scanc, m_scand;
    logic [7:0]   m_seg;
    logic [N-1:0] m_sel;
    logic         m_pulse;

    function automatic int digit_of(input int i);
        return (i < N) ? i : 2 * N - 1 - i;
    endfunction

    function automatic int row_of(input int i);
        return (i < N) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_stepc = 0; m_scanc = 0; m_scand = 0;
        m_seg = 8'h00; m_sel = '0; m_pulse = 1'b0;
    endtask

    // Predict the effect of the coming clock edge from the current inputs
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        m_sel   = enable ? (N'(1) << m_scand) : '0;
        m_seg   = (enable && m_scand == digit_of(m_idx)) ?
                  ((row_of(m_idx) == 1) ? 8'h63 : 8'h5C) : 8'h00;
        m_pulse = 1'b0;
        if (restart) begin
            m_idx = 0; m_stepc = 0;
        end else if (!enable) begin
            m_stepc = 0;
        end else if (!pause) begin
            if (m_stepc == STEP - 1) begin
                m_stepc = 0;
                m_pulse = 1'b1;
                m_idx   = dir ? (m_idx + 2 * N - 1) % (2 * N) : (m_idx + 1) % (2 * N);
            end else begin
                m_stepc++;
            end
        end
        m_scanc = (m_scanc + 1) % SCAN;
        if (m_scanc == 0) m_scand = (m_scand + 1) % N;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("seg_display", seg_display, m_seg);
        check("digit_sel", digit_sel, m_sel);
        check("step_pulse", step_pulse, m_pulse);
        check("pos_digit", pos_digit, rst ? 0 : digit_of(m_idx));
        check("pos_row", pos_row, rst ? 0 : row_of(m_idx));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // Run until the next step_pulse, bounded; n = cycles taken (0 = timeout)
    task automatic wait_step(output int n);
        n = 0;
        for (int k = 1; k <= 3 * STEP; k++) begin
            cyc();
            if (step_pulse) begin
                n = k;
                break;
            end
        end
        vectors++;
        if (n == 0) begin
            miscompares++;
            $display("FAIL step_timeout: no step_pulse within %0d cycles, required one", 3 * STEP);
        end
    endtask

    typedef struct {
        logic d;
        int   exp_digit;
        int   exp_row;
    } step_vec_t;

    step_vec_t tbl[10];

    // Observe 8 scan cycles; circle must appear only in slot 2 with pattern exp
    task automatic scan_check(input string name, input logic [7:0] exp);
        logic [N-1:0] seen;
        int           hits;
        seen = '0;
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            seen |= digit_sel;
            if (digit_sel == 4'b0100) hits++;
            check(name, seg_display, (digit_sel == 4'b0100) ? exp : 8'h00);
            check({name, "_onehot"}, $onehot(digit_sel), 1);
        end
        check({name, "_cover"}, seen, 4'hF);
        check({name, "_slot_len"}, hits, SCAN);
        $display("scan %s: pattern %02h verified over 8 cycles", name, exp);
    endtask

    int           n;
    int           held_digit, held_row, pulses;
    logic [N-1:0] seen_sel;

    initial begin
        tbl[0] = '{1'b0, 1, 1}; tbl[1] = '{1'b0, 2, 1};
        tbl[2] = '{1'b0, 3, 1}; tbl[3] = '{1'b0, 3, 0};
        tbl[4] = '{1'b0, 2, 0}; tbl[5] = '{1'b0, 1, 0};
        tbl[6] = '{1'b0, 0, 0}; tbl[7] = '{1'b0, 0, 1};
        tbl[8] = '{1'b1, 0, 0}; tbl[9] = '{1'b1, 1, 0};

        rst = 1'b0; enable = 1'b0; pause = 1'b0; dir = 1'b0; restart = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset_seg", seg_display, 0);
        check("reset_sel", digit_sel, 0);
        check("reset_pulse", step_pulse, 0);
        check("reset_pos_digit", pos_digit, 0);
        check("reset_pos_row", pos_row, 0);
        enable = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;

        // Step table: first entry also measures latency out of reset
        for (int i = 0; i < 10; i++) begin
            dir = tbl[i].d;
            wait_step(n);
            check("step_latency", n, STEP);
            check("step_pos_digit", pos_digit, tbl[i].exp_digit);
            check("step_pos_row", pos_row, tbl[i].exp_row);
            $display("step %0d dir=%0d pos_digit=%0d pos_row=%0d latency=%0d",
                     i, tbl[i].d, pos_digit, pos_row, n);
        end

        // Scan at idx 2 then idx 5
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check("restart_pulse", step_pulse, 0);
        check("restart_digit", pos_digit, 0);
        check("restart_row", pos_row, 1);
        dir = 1'b0;
        repeat (2) wait_step(n);
        pause = 1'b1;
        scan_check("scan_idx2", 8'h63);
        pause = 1'b0;
        repeat (3) wait_step(n);
        pause = 1'b1;
        scan_check("scan_idx5", 8'h5C);

        // Long pause: position frozen, scan still moving
        held_digit = pos_digit;
        held_row   = pos_row;
        pulses     = 0;
        seen_sel   = '0;
        repeat (20) begin
            cyc();
            pulses += step_pulse;
            seen_sel |= digit_sel;
        end
        check("pause_pulses", pulses, 0);
        check("pause_digit", pos_digit, held_digit);
        check("pause_row", pos_row, held_row);
        check("pause_scan", seen_sel, 4'hF);
        $display("pause 20 cycles: pos_digit=%0d pos_row=%0d", pos_digit, pos_row);

        // Blanking
        pause  = 1'b0;
        enable = 1'b0;
        cyc();
        repeat (6) begin
            cyc();
            check("blank_seg", seg_display, 0);
            check("blank_sel", digit_sel, 0);
            check("blank_pulse", step_pulse, 0);
        end
        check("blank_digit", pos_digit, held_digit);
        check("blank_row", pos_row, held_row);
        $display("blank: outputs dark, pos_digit=%0d held", pos_digit);

        // Restart landing exactly on a timer wrap
        enable = 1'b1;
        for (int k = 0; k < 10 && m_stepc != STEP - 1; k++) cyc();
        check("wrap_reached", m_stepc, STEP - 1);
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check("wrap_restart_pulse", step_pulse, 0);
        check("wrap_restart_digit", pos_digit, 0);
        check("wrap_restart_row", pos_row, 1);
        wait_step(n);
        check("post_restart_latency", n, STEP);
        $display("restart on wrap: cleared, next step after %0d cycles", n);

        // Async reset mid-step at idx 3, step count 2
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        repeat (3) wait_step(n);
        check("pre_rst_digit", pos_digit, 3);
        check("pre_rst_row", pos_row, 1);
        repeat (2) cyc();
        rst = 1'b1;
        model_reset();
        #1;
        check("async_seg", seg_display, 0);
        check("async_sel", digit_sel, 0);
        check("async_pulse", step_pulse, 0);
        check("async_digit", pos_digit, 0);
        check("async_row", pos_row, 0);
        cyc();
        rst = 1'b0;
        wait_step(n);
        check("post_rst_latency", n, STEP);
        check("post_rst_digit", pos_digit, 1);
        check("post_rst_row", pos_row, 1);
        $display("async reset: outputs cleared, first step after %0d cycles", n);

        // Randomized inputs against the model
        for (int k = 0; k < 400; k++) begin
            enable  = ($urandom % 8) != 0;
            pause   = ($urandom % 4) == 0;
            dir     = $urandom % 2;
            restart = ($urandom % 16) == 0;
            cyc();
        end
        $display("random: 400 cycles applied");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
